coco_timer: RTL and testbench
=============================

Name: coco_timer

Overview:
- Programmable down-counting timer on the processor bus, directly downstream of the CPU core.
- The system bridge decodes the CPU's bus address, write enable and write data. It routes windows 0x7F00–0x7F0B (timer 0) and 0x7F10–0x7F1B (timer 1) to two instances of this block.
- Each instance's IRQ drives one bit of the CPU's HWInt[7:2]; its RD returns through the bridge as bus read data.
- The CPU already rejects non-word and out-of-range accesses, so this block sees only word accesses at offsets 0x0, 0x4 and 0x8.

Parameters:
- PRESET_INIT, 32'h0000_0000, reset value of the PRESET register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  2  word offset, equal to bus address bits [3:2]: 00 CTRL, 01 PRESET, 10 COUNT, 11 unused.
- WE  input  1  write strobe, already qualified by the bridge for this instance.
- WD  input  32  write data.
- RD  output  32  read data, combinational from Addr.
- IRQ  output  1  interrupt request, equal to irq_flag & CTRL.IM.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Registers:
  - CTRL[3:0]: bit0 Enable, bits[2:1] Mode (00 = one-shot, 01 = auto-reload; 10 and 11 behave as 00), bit3 IM (interrupt mask).
  - PRESET[31:0].
  - COUNT[31:0], read-only.
  - irq_flag, internal.
  - state, one of IDLE, LOAD, CNT, INT.
- Reset values: CTRL=0, PRESET=PRESET_INIT, COUNT=0, irq_flag=0, state=IDLE. IRQ is therefore 0 and RD follows Addr.
- Read mux:
  - 00 → {28'b0, CTRL}
  - 01 → PRESET
  - 10 → COUNT
  - 11 → 32'b0
  - No side effects on read.
- Bus writes (take effect on the clock edge where WE=1):
  - Addr 00: CTRL ← WD[3:0]; irq_flag ← 0.
  - Addr 01: PRESET ← WD; irq_flag ← 0. The current COUNT is unaffected; the new value is used at the next LOAD.
  - Addr 10 or 11: ignored, no state change.
- FSM, evaluated every edge using the register values before the edge:
  - IDLE: if Enable → LOAD; else stay. COUNT holds.
  - LOAD: COUNT ← PRESET; irq_flag ← 0; → CNT.
  - CNT:
    - if !Enable → IDLE, COUNT frozen;
    - else if COUNT > 1 → COUNT ← COUNT−1;
    - else (COUNT is 0 or 1) → COUNT ← 0, irq_flag ← 1, → INT.
  - INT:
    - Mode one-shot: Enable ← 0; irq_flag held; → IDLE.
    - Mode auto-reload: irq_flag ← 0; → IDLE. Enable stays 1, so the FSM reloads.
- Simultaneous events:
  - A CPU write to CTRL in the same edge as the INT-state Enable clear wins: CTRL takes WD[3:0].
  - A CPU write that clears irq_flag in the same edge as CNT setting it loses: irq_flag ends at 1.
- Timing, preset N ≥ 1, Enable written at edge 0:
  - LOAD at edge 1, COUNT=N after edge 2.
  - irq_flag=1 after edge N+2.
  - Auto-reload repeats with period N+3 cycles, each IRQ pulse 1 cycle wide.
  - Preset 0 behaves as preset 1.
- Disable mid-count: COUNT holds its value. Re-enabling goes IDLE→LOAD, so the count restarts from PRESET; it does not resume.
- Reset asserted mid-operation returns all registers to their reset values on that edge, regardless of WE.

Test Plan:
- Reset check: after reset, RD is 0 at Addr 00 and 10 and PRESET_INIT at Addr 01; IRQ=0; a write to Addr 10 with 0xFFFF leaves COUNT at 0.
- One-shot: PRESET=5, CTRL=0x9 at edge 0.
  - IRQ rises after edge 7 and stays high.
  - CTRL reads 0x8 after edge 8; COUNT reads 0.
  - A write of CTRL=0x8 drops IRQ on the next edge.
- Auto-reload: PRESET=5, CTRL=0xB. IRQ pulses 1 cycle after edges 7, 15 and 23, low otherwise.
- Mask: one-shot with CTRL=0x1 → IRQ stays 0. A later write of CTRL=0x8 clears irq_flag, so IRQ still stays 0.
- Disable mid-count:
  - PRESET=10, CTRL=0x9.
  - Write CTRL=0x8 when COUNT=6 → COUNT stays at 5 or 6 (no further decrement), IRQ=0.
  - Re-enable → COUNT reloads to 10 two edges later.
- Collision: in one-shot mode, write CTRL=0x9 on the same edge the FSM is in INT → Enable reads 1 afterwards and a new count starts from PRESET. Also write PRESET=3 mid-count → the current period is unchanged, and the next reload uses 3.

Source files
------------

// File: rtl/coco_timer.sv
// Programmable down-counting bus timer: CTRL/PRESET/COUNT registers, a load/count/expire
// sequencer and a maskable interrupt. Two instances sit behind the system bridge.
module coco_timer #(
  parameter logic [31:0] PRESET_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic enable;
  logic auto_reload;
  logic wr_ctrl;
  logic wr_preset;

  assign enable      = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign wr_ctrl     = WE && (Addr == 2'b00);
  assign wr_preset   = WE && (Addr == 2'b01);

  // Statement order sets collision priority: a bus write clears irq_flag before
  // the CNT expiry can set it, and a CTRL write overrides the INT enable clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= PRESET_INIT;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_ctrl || wr_preset)
        irq_flag <= 1'b0;
      if (wr_preset)
        preset <= WD;

      case (state)
        IDLE: begin
          if (enable)
            state <= LOAD;
        end
        LOAD: begin
          count    <= preset;
          irq_flag <= 1'b0;
          state    <= CNT;
        end
        CNT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          if (auto_reload)
            irq_flag <= 1'b0;
          else
            ctrl[0] <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (wr_ctrl)
        ctrl <= WD[3:0];
    end
  end

  always_comb begin
    RD = '0;
    case (Addr)
      2'b00:   RD = {28'b0, ctrl};
      2'b01:   RD = preset;
      2'b10:   RD = count;
      default: RD = '0;
    endcase
  end

  assign IRQ = irq_flag & ctrl[3];

endmodule

// File: tb/tb_coco_timer.sv
// Bench for coco_timer: directed timing scenarios plus randomized bus traffic,
// all compared against a behavioural model of the timer's register rules.
module tb_coco_timer;

  localparam logic [31:0] PINIT = 32'hA5A5_0003;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  coco_timer #(.PRESET_INIT(PINIT)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .WD    (WD),
    .RD    (RD),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference model: phase of the load/count/expire cycle plus register copies.
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_EXPIRED} mphase_t;
  mphase_t     m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;

  task automatic model_edge(input logic rst, input logic we, input logic [1:0] a,
                            input logic [31:0] wd);
    logic [3:0]  c;
    logic [31:0] p;
    logic [31:0] n;
    logic        f;
    mphase_t     ph;
    bit          fired;
    if (rst) begin
      m_phase = M_IDLE; m_ctrl = 4'h0; m_preset = PINIT; m_count = 0; m_flag = 1'b0;
      return;
    end
    c = m_ctrl; p = m_preset; n = m_count; f = m_flag; ph = m_phase; fired = 0;
    if (m_phase == M_IDLE && m_ctrl[0]) ph = M_LOAD;
    if (m_phase == M_LOAD) begin n = m_preset; f = 1'b0; ph = M_RUN; end
    if (m_phase == M_RUN) begin
      if (!m_ctrl[0]) ph = M_IDLE;
      else if (m_count <= 1) begin n = 0; fired = 1; ph = M_EXPIRED; end
      else n = m_count - 1;
    end
    if (m_phase == M_EXPIRED) begin
      ph = M_IDLE;
      if (m_ctrl[2:1] == 2'b01) f = 1'b0;
      else c[0] = 1'b0;
    end
    if (we && a == 2'd1) p = wd;
    if (we && a == 2'd0) c = wd[3:0];
    if (we && a <= 2'd1) f = 1'b0;
    if (fired) f = 1'b1;
    m_phase = ph; m_ctrl = c; m_preset = p; m_count = n; m_flag = f;
  endtask

  logic [31:0] cur_ctrl, cur_preset, cur_count;
  logic        cur_irq;

  task automatic step(input logic rst, input logic we, input logic [1:0] a,
                      input logic [31:0] wd);
    reset = rst; WE = we; Addr = a; WD = wd;
    @(posedge clk);
    model_edge(rst, we, a, wd);
    #1;
    reset = 1'b0; WE = 1'b0;
    Addr = 2'd0; #1; cur_ctrl   = RD;
    Addr = 2'd1; #1; cur_preset = RD;
    Addr = 2'd2; #1; cur_count  = RD;
    Addr = 2'd3; #1; check("rd_unused", RD, 32'h0);
    cur_irq = IRQ;
    check("m_ctrl",   cur_ctrl,   {28'b0, m_ctrl});
    check("m_preset", cur_preset, m_preset);
    check("m_count",  cur_count,  m_count);
    check("m_irq",    32'(cur_irq), 32'(m_flag & m_ctrl[3]));
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 2'd0, 32'h0);
    step(1'b1, 1'b1, 2'd0, 32'hF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; WE = 1'b0; Addr = 2'd0; WD = 32'h0;

    // Reset state
    do_reset();
    check("rst_ctrl",   cur_ctrl,   32'h0);
    check("rst_preset", cur_preset, PINIT);
    check("rst_count",  cur_count,  32'h0);
    check("rst_irq",    32'(cur_irq), 32'h0);
    step(1'b0, 1'b1, 2'd2, 32'hFFFF);
    check("count_ro",   cur_count,  32'h0);

    // One-shot, PRESET=5
    step(1'b0, 1'b1, 2'd1, 32'd5);
    step(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      idle(1);
      check("os_irq", 32'(cur_irq), 32'(k == 7));
    end
    idle(1);
    check("os_ctrl",  cur_ctrl,  32'h8);
    check("os_count", cur_count, 32'h0);
    check("os_hold",  32'(cur_irq), 32'h1);
    step(1'b0, 1'b1, 2'd0, 32'h8);
    check("os_clr",   32'(cur_irq), 32'h0);

    // Auto-reload, PRESET=5
    do_reset();
    step(1'b0, 1'b1, 2'd1, 32'd5);
    step(1'b0, 1'b1, 2'd0, 32'hB);
    for (int k = 1; k <= 25; k++) begin
      idle(1);
      check("ar_irq", 32'(cur_irq), 32'(k == 7 || k == 15 || k == 23));
    end

    // Masked interrupt
    do_reset();
    step(1'b0, 1'b1, 2'd1, 32'd5);
    step(1'b0, 1'b1, 2'd0, 32'h1);
    for (int k = 1; k <= 9; k++) begin
      idle(1);
      check("mask_irq", 32'(cur_irq), 32'h0);
    end
    step(1'b0, 1'b1, 2'd0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check("mask_after", 32'(cur_irq), 32'h0);
    end

    // Disable mid-count, then re-enable
    do_reset();
    step(1'b0, 1'b1, 2'd1, 32'd10);
    step(1'b0, 1'b1, 2'd0, 32'h9);
    idle(6);
    check("dis_pre", cur_count, 32'd6);
    step(1'b0, 1'b1, 2'd0, 32'h8);
    check("dis_cnt", cur_count, 32'd5);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check("dis_hold", cur_count, 32'd5);
      check("dis_irq",  32'(cur_irq), 32'h0);
    end
    step(1'b0, 1'b1, 2'd0, 32'h9);
    idle(1);
    check("ren_load", cur_count, 32'd5);
    idle(1);
    check("ren_cnt",  cur_count, 32'd10);

    // Collision: CTRL write while in INT, PRESET write mid-count
    do_reset();
    step(1'b0, 1'b1, 2'd1, 32'd5);
    step(1'b0, 1'b1, 2'd0, 32'h9);
    idle(7);
    check("col_irq", 32'(cur_irq), 32'h1);
    step(1'b0, 1'b1, 2'd0, 32'h9);
    check("col_ctrl",  cur_ctrl, 32'h9);
    check("col_irq0",  32'(cur_irq), 32'h0);
    idle(2);
    check("col_load",  cur_count, 32'd5);
    step(1'b0, 1'b1, 2'd1, 32'd3);
    check("col_cnt",   cur_count, 32'd4);
    check("col_pre",   cur_preset, 32'd3);
    for (int e = 12; e <= 15; e++) begin
      idle(1);
      check("col_fire", 32'(cur_irq), 32'(e == 15));
    end
    idle(1);
    step(1'b0, 1'b1, 2'd0, 32'h9);
    idle(2);
    check("col_reload", cur_count, 32'd3);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      r = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 3) == 0);
      a = 2'($urandom_range(0, 3));
      if (a == 2'd1 && $urandom_range(0, 7) != 0) d = 32'($urandom_range(0, 12));
      else d = $urandom();
      step(r, w, a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
